// File: rtl/mine_placer_pkg.sv
// mine_placer_pkg
//   Shared definitions for the mine placer and the boards it feeds:
//   - placerState_t : FSM state encoding of the placer
//   - LFSR_TAPS     : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - DEFAULT_SEED  : LFSR start value, also substituted for a zero seed
//   - coordBits()   : coordinate width for a board dimension
package mine_placer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    CHECK = 3'd2,
    PLACE = 3'd3,
    DONE  = 3'd4
  } placerState_t;

  // Right-shifting Galois form: bit k of the mask is XORed into the
  // shifted value whenever the bit shifted out is 1.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Coordinate width for a dimension of 'cells' entries. A one-entry
  // dimension still gets a 1-bit coordinate so ports never collapse.
  function automatic int coordBits(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// lfsr16
//   16-bit Galois LFSR that advances on every rising clock edge and is
//   never stalled. A zero seed would lock the register at zero, so it is
//   replaced by DEFAULT_SEED.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous, active-low
//   seed   in   16-bit reset value
//   value  out  current register contents
module lfsr16
  import mine_placer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] valueReg;
  logic [15:0] valueNext;
  logic [15:0] startValue;

  assign startValue = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  // Each bit takes its upper neighbour, XORed with the bit shifted out of
  // position 0 wherever the tap mask is set. The top bit shifts in a zero.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gBit
      if (gi == 15) begin : gTop
        assign valueNext[gi] = LFSR_TAPS[gi] & valueReg[0];
      end else begin : gMid
        assign valueNext[gi] = valueReg[gi+1] ^ (LFSR_TAPS[gi] & valueReg[0]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valueReg <= startValue;
    end else begin
      valueReg <= valueNext;
    end
  end

  assign value = valueReg;

endmodule

// File: rtl/mine_placer.sv
// mine_placer
//   Places mineCount mines on distinct pseudo-random cells of a
//   width x height board, never on the protected first-click cell.
//   Every placement is a one-cycle placeEn pulse that the top level uses
//   as the mine board write (writeEn = writeValue = placeEn) and as the
//   adjacency board increment. Duplicates are rejected by reading the
//   mine board through its combinational read port, which this block
//   owns while busy is high.
// Parameters:
//   width, height  board size in cells
//   mineCount      mines per game, 1 .. width*height-1
//   seed           LFSR reset value (zero means DEFAULT_SEED)
// Ports:
//   clk            clock, all state on the rising edge
//   reset          asynchronous, active-low
//   start          game request, honoured only while idle
//   safeX, safeY   protected cell, captured together with start
//   readX, readY   mine-board read address (current candidate)
//   readValue      mine-board cell at readX/readY, same cycle
//   placeX, placeY placement coordinates, valid with placeEn
//   placeEn        one-cycle placement strobe
//   busy           high from the first draw through the done cycle
//   done           one-cycle pulse after the last placement
module mine_placer
  import mine_placer_pkg::*;
#(
  parameter int          width     = 8,
  parameter int          height    = 8,
  parameter int          mineCount = 10,
  parameter logic [15:0] seed      = DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [coordBits(width)-1:0]  safeX,
  input  logic [coordBits(height)-1:0] safeY,
  output logic [coordBits(width)-1:0]  readX,
  output logic [coordBits(height)-1:0] readY,
  input  logic                         readValue,
  output logic [coordBits(width)-1:0]  placeX,
  output logic [coordBits(height)-1:0] placeY,
  output logic                         placeEn,
  output logic                         busy,
  output logic                         done
);

  localparam int XW = coordBits(width);
  localparam int YW = coordBits(height);
  localparam int CW = $clog2(mineCount + 1);

  placerState_t  stateReg;
  placerState_t  stateNext;

  logic [XW-1:0] candXReg;
  logic [YW-1:0] candYReg;
  logic [XW-1:0] safeXReg;
  logic [YW-1:0] safeYReg;
  logic [CW-1:0] placedReg;

  logic [15:0]   lfsrValue;
  logic          candOutOfRange;
  logic          candIsSafe;
  logic          candRejected;
  logic          lastPlacement;

  // Only the low XW+YW bits feed the candidate; the rest are reduced here
  // so the unused upper bits are accounted for.
  logic          unusedLfsrBits;
  assign unusedLfsrBits = ^lfsrValue;

  lfsr16 uLfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (seed),
    .value (lfsrValue)
  );

  // Candidate qualification, evaluated during CHECK. Out-of-range values
  // only occur for non power-of-two dimensions; they are simply redrawn.
  assign candOutOfRange = (int'(candXReg) >= width) || (int'(candYReg) >= height);
  assign candIsSafe     = (candXReg == safeXReg) && (candYReg == safeYReg);
  assign candRejected   = candOutOfRange || candIsSafe || readValue;

  // The counter still holds the pre-increment value during PLACE.
  assign lastPlacement  = (placedReg == CW'(mineCount - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candXReg  <= '0;
      candYReg  <= '0;
      safeXReg  <= '0;
      safeYReg  <= '0;
      placedReg <= '0;
    end else begin
      if ((stateReg == IDLE) && start) begin
        safeXReg  <= safeX;
        safeYReg  <= safeY;
        placedReg <= '0;
      end
      if (stateReg == DRAW) begin
        candXReg <= lfsrValue[XW-1:0];
        candYReg <= lfsrValue[XW+YW-1:XW];
      end
      if (stateReg == PLACE) begin
        placedReg <= placedReg + CW'(1);
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    placeEn   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (stateReg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          stateNext = DRAW;
        end
      end
      DRAW: begin
        stateNext = CHECK;
      end
      CHECK: begin
        stateNext = candRejected ? DRAW : PLACE;
      end
      PLACE: begin
        placeEn   = 1'b1;
        stateNext = lastPlacement ? DONE : DRAW;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        busy      = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // The candidate register drives both addresses: it is the read address
  // during CHECK and the write address during PLACE, and it resets to 0.
  assign readX  = candXReg;
  assign readY  = candYReg;
  assign placeX = candXReg;
  assign placeY = candYReg;

endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer
//   Three placers side by side: 8x8/10 mines (default seed), 8x8/63 mines
//   (seed 0, i.e. 16'hACE1) and 6x5/8 mines (seed 16'h1234). Each drives
//   its own behavioural mine board (combinational read) and adjacency
//   board. When a game starts, a reference model replays the placement
//   rules (2 cycles per rejected draw, 3 per placement) against the LFSR
//   sequence and queues every expected placeEn/done event with its cycle;
//   a monitor pops and compares whenever the DUT presents an event.
module tb_mine_placer;

  localparam int          wArr    [3] = '{8, 8, 6};
  localparam int          hArr    [3] = '{8, 8, 5};
  localparam int          mcArr   [3] = '{10, 63, 8};
  localparam logic [15:0] rawSeed [3] = '{16'hACE1, 16'h0000, 16'h1234};

  logic       clk_tb;
  logic [2:0] reset_tb;
  logic [2:0] start;
  logic [2:0] safeX  [3];
  logic [2:0] safeY  [3];
  logic [2:0] readX  [3];
  logic [2:0] readY  [3];
  logic [2:0] placeX [3];
  logic [2:0] placeY [3];
  logic [2:0] readValue;
  logic [2:0] placeEn;
  logic [2:0] busy;
  logic [2:0] done;

  bit          mineBoard [3][64];
  int          adjBoard  [3][64];
  bit          refBoard  [3][64];
  bit          clearReq  [3];
  logic [15:0] lfsrModel [3];
  int          expQ      [3][$];
  int          busyFrom  [3];
  int          busyTo    [3];
  int          placeCount[3];
  int          doneCount [3];
  int          cyc         = 0;
  int          nCompared   = 0;
  int          nMismatched = 0;

  mine_placer #(.width(8), .height(8), .mineCount(10)) dutA (
    .clk(clk_tb), .reset(reset_tb[0]), .start(start[0]),
    .safeX(safeX[0]), .safeY(safeY[0]), .readX(readX[0]), .readY(readY[0]),
    .readValue(readValue[0]), .placeX(placeX[0]), .placeY(placeY[0]),
    .placeEn(placeEn[0]), .busy(busy[0]), .done(done[0])
  );

  mine_placer #(.width(8), .height(8), .mineCount(63), .seed(16'h0000)) dutB (
    .clk(clk_tb), .reset(reset_tb[1]), .start(start[1]),
    .safeX(safeX[1]), .safeY(safeY[1]), .readX(readX[1]), .readY(readY[1]),
    .readValue(readValue[1]), .placeX(placeX[1]), .placeY(placeY[1]),
    .placeEn(placeEn[1]), .busy(busy[1]), .done(done[1])
  );

  mine_placer #(.width(6), .height(5), .mineCount(8), .seed(16'h1234)) dutC (
    .clk(clk_tb), .reset(reset_tb[2]), .start(start[2]),
    .safeX(safeX[2]), .safeY(safeY[2]), .readX(readX[2]), .readY(readY[2]),
    .readValue(readValue[2]), .placeX(placeX[2]), .placeY(placeY[2]),
    .placeEn(placeEn[2]), .busy(busy[2]), .done(done[2])
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  always @(posedge clk_tb) cyc <= cyc + 1;

  // Boards are stored with a row stride of 8 for every instance.
  assign readValue[0] = mineBoard[0][{readY[0], readX[0]}];
  assign readValue[1] = mineBoard[1][{readY[1], readX[1]}];
  assign readValue[2] = mineBoard[2][{readY[2], readX[2]}];

  always @(posedge clk_tb) begin
    for (int i = 0; i < 3; i++) begin
      if (clearReq[i]) begin
        for (int c = 0; c < 64; c++) begin
          mineBoard[i][c] <= 1'b0;
          adjBoard[i][c]  <= 0;
        end
      end else if (placeEn[i] === 1'b1) begin
        mineBoard[i][{placeY[i], placeX[i]}] <= 1'b1;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0) &&
                int'(placeX[i]) + dx >= 0 && int'(placeX[i]) + dx < wArr[i] &&
                int'(placeY[i]) + dy >= 0 && int'(placeY[i]) + dy < hArr[i]) begin
              adjBoard[i][(int'(placeY[i]) + dy) * 8 + int'(placeX[i]) + dx] <=
                adjBoard[i][(int'(placeY[i]) + dy) * 8 + int'(placeX[i]) + dx] + 1;
            end
          end
        end
      end
    end
  end

  // Reference LFSR: x^16+x^14+x^13+x^11+1, one step per clock while out of reset.
  function automatic logic [15:0] stepLfsr(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk_tb) begin
    for (int i = 0; i < 3; i++) begin
      lfsrModel[i] <= reset_tb[i] ? stepLfsr(lfsrModel[i])
                                  : ((rawSeed[i] == 16'h0000) ? 16'hACE1 : rawSeed[i]);
    end
  end

  task automatic check(input string name, input int got, input int want);
    nCompared++;
    if (got != want) begin
      nMismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Event code: cycle << 8 | done << 7 | y << 3 | x
  function automatic string describe(input int code);
    if (code < 0) return "no event";
    return $sformatf("%s(%0d,%0d)@%0d", ((code & 128) != 0) ? "done" : "place",
                     code & 7, (code >> 3) & 7, code >> 8);
  endfunction

  task automatic checkEvent(input int i, input int got);
    int want;
    want = (expQ[i].size() == 0) ? -1 : expQ[i].pop_front();
    nCompared++;
    if (got != want) begin
      nMismatched++;
      $display("FAIL event inst%0d: got %s, required %s", i, describe(got), describe(want));
    end
  endtask

  // Called in the first DRAW cycle: the LFSR model holds the value the DUT
  // draws its first candidate from. d is that cycle's number.
  task automatic planGame(input int i, input int sx, input int sy);
    logic [15:0] l;
    int d, t, placed, guard, cx, cy;
    l = lfsrModel[i];
    d = cyc;
    t = 0;
    placed = 0;
    guard = 0;
    for (int c = 0; c < 64; c++) refBoard[i][c] = 1'b0;
    while (placed < mcArr[i] && guard < 40000) begin
      guard++;
      cx = int'(l[2:0]);   // all three instances use 3-bit coordinates
      cy = int'(l[5:3]);
      if (cx >= wArr[i] || cy >= hArr[i] || (cx == sx && cy == sy) || refBoard[i][cy*8+cx]) begin
        l = stepLfsr(stepLfsr(l));
        t += 2;
      end else begin
        refBoard[i][cy*8+cx] = 1'b1;
        expQ[i].push_back(((d + t + 2) << 8) | (cy << 3) | cx);
        placed++;
        l = stepLfsr(stepLfsr(stepLfsr(l)));
        t += 3;
      end
    end
    expQ[i].push_back(((d + t) << 8) | 128);
    busyTo[i] = d + t;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk_tb);
      for (int i = 0; i < 3; i++) begin
        if (reset_tb[i] === 1'b1) begin
          check($sformatf("busy inst%0d cycle %0d", i, cyc), int'(busy[i]),
                int'(cyc >= busyFrom[i] && cyc <= busyTo[i]));
          if (placeEn[i] === 1'b1) begin
            placeCount[i]++;
            $display("inst%0d place (%0d,%0d) cycle %0d", i, placeX[i], placeY[i], cyc);
            if (i == 2) check("inst2 placement inside 6x5", int'(placeX[2] < 3'd6 && placeY[2] < 3'd5), 1);
            checkEvent(i, (cyc << 8) | (int'(placeY[i]) << 3) | int'(placeX[i]));
          end
          if (done[i] === 1'b1) begin
            doneCount[i]++;
            $display("inst%0d done cycle %0d", i, cyc);
            checkEvent(i, (cyc << 8) | 128);
          end
        end
      end
    end
  end

  task automatic clearBoard(input int i);
    clearReq[i] = 1'b1;
    @(negedge clk_tb);
    clearReq[i] = 1'b0;
  endtask

  task automatic startGames(input logic [2:0] mask);
    repeat ($urandom_range(0, 6)) @(negedge clk_tb);
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        placeCount[i] = 0;
        doneCount[i]  = 0;
        busyFrom[i]   = cyc + 1;
        busyTo[i]     = 1 << 30;
      end
    end
    start = mask;
    @(negedge clk_tb);
    start = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) planGame(i, int'(safeX[i]), int'(safeY[i]));
    end
  endtask

  task automatic waitDone(input logic [2:0] mask, input int limit);
    int k;
    bit all;
    k = 0;
    all = 1'b0;
    while (k < limit && !all) begin
      @(negedge clk_tb);
      #1;
      k++;
      all = 1'b1;
      for (int i = 0; i < 3; i++) if (mask[i] && doneCount[i] == 0) all = 1'b0;
    end
    check("games finished within cycle budget", int'(all), 1);
  endtask

  task automatic finalChecks(input int i);
    int ones, boardDiff, adjDiff, refAdj;
    ones = 0;
    boardDiff = 0;
    adjDiff = 0;
    for (int y = 0; y < hArr[i]; y++) begin
      for (int x = 0; x < wArr[i]; x++) begin
        ones += int'(mineBoard[i][y*8+x]);
        if (mineBoard[i][y*8+x] != refBoard[i][y*8+x]) boardDiff++;
        refAdj = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < wArr[i] && y + dy >= 0 && y + dy < hArr[i])
              refAdj += int'(refBoard[i][(y+dy)*8 + x + dx]);
        if (adjBoard[i][y*8+x] != refAdj) adjDiff++;
      end
    end
    check($sformatf("inst%0d placeEn pulses", i), placeCount[i], mcArr[i]);
    check($sformatf("inst%0d done pulses", i), doneCount[i], 1);
    check($sformatf("inst%0d events left over", i), expQ[i].size(), 0);
    check($sformatf("inst%0d mines on board", i), ones, mcArr[i]);
    check($sformatf("inst%0d cells differing from reference board", i), boardDiff, 0);
    check($sformatf("inst%0d adjacency cells differing", i), adjDiff, 0);
    check($sformatf("inst%0d safe cell mine", i), int'(mineBoard[i][{safeY[i], safeX[i]}]), 0);
  endtask

  initial begin
    reset_tb = 3'b000;
    start    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      safeX[i] = 3'd0;
      safeY[i] = 3'd0;
      clearReq[i] = 1'b0;
      busyFrom[i] = 1 << 30;
      busyTo[i] = -1;
      placeCount[i] = 0;
      doneCount[i] = 0;
    end
    repeat (3) @(negedge clk_tb);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset inst%0d busy", i), int'(busy[i]), 0);
      check($sformatf("reset inst%0d placeEn", i), int'(placeEn[i]), 0);
      check($sformatf("reset inst%0d done", i), int'(done[i]), 0);
      check($sformatf("reset inst%0d readX", i), int'(readX[i]), 0);
      check($sformatf("reset inst%0d readY", i), int'(readY[i]), 0);
      check($sformatf("reset inst%0d placeX", i), int'(placeX[i]), 0);
      check($sformatf("reset inst%0d placeY", i), int'(placeY[i]), 0);
    end
    #2 reset_tb = 3'b111;
    repeat (5) @(negedge clk_tb);

    // Game 1 on all three instances at once.
    safeX[0] = 3'd3;
    safeY[0] = 3'd3;
    safeX[1] = 3'd0;
    safeY[1] = 3'd0;
    safeX[2] = 3'($urandom_range(0, 5));
    safeY[2] = 3'($urandom_range(0, 4));
    startGames(3'b111);
    // A second start while busy must be ignored.
    repeat (8) @(negedge clk_tb);
    start[0] = 1'b1;
    @(negedge clk_tb);
    start[0] = 1'b0;
    waitDone(3'b111, 60000);
    for (int i = 0; i < 3; i++) finalChecks(i);

    // Game 2 on instance A, interrupted by reset after the 4th placement.
    clearBoard(0);
    safeX[0] = 3'($urandom_range(0, 7));
    safeY[0] = 3'($urandom_range(0, 7));
    startGames(3'b001);
    begin
      int k;
      k = 0;
      while (k < 500 && placeCount[0] < 4) begin
        @(negedge clk_tb);
        #1;
        k++;
      end
    end
    check("inst0 reached 4th placement", int'(placeCount[0] == 4), 1);
    #1;
    reset_tb[0] = 1'b0;
    expQ[0].delete();
    busyTo[0] = -1;
    #1;
    check("placeEn low right after reset", int'(placeEn[0]), 0);
    check("busy low right after reset", int'(busy[0]), 0);
    check("done low right after reset", int'(done[0]), 0);
    repeat (2) @(negedge clk_tb);
    #2 reset_tb[0] = 1'b1;
    repeat (6) @(negedge clk_tb);
    #1;
    check("no placement after reset release", placeCount[0], 4);

    // Game 3 on instance A after the reset: starts cleanly from IDLE.
    clearBoard(0);
    safeX[0] = 3'($urandom_range(0, 7));
    safeY[0] = 3'($urandom_range(0, 7));
    startGames(3'b001);
    waitDone(3'b001, 20000);
    finalChecks(0);

    repeat (3) @(negedge clk_tb);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
